// File: rtl/booth_adder_server.sv
`default_nettype none
// booth_adder_server: multi-cycle chunked ripple adder answering the Booth multiplier's Adder callee port.
// Optional saturation on signed overflow is enabled with the ADDER_SAT_EN macro.
module booth_adder_server #(
   parameter int WIDTH = 25,
   parameter int CHUNK = 5
) (
   input  logic             CLK,
   input  logic             RSTK,
   input  logic             Adder_valid,
   input  logic [WIDTH-1:0] Adder_datain1,
   input  logic [WIDTH-1:0] Adder_datain2,
   output logic [WIDTH-1:0] Adder_dataout,
   output logic             Adder_carryout,
   output logic [1:0]       Adder_Exc,
   output logic             Adder_ack
);

   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int PADW   = NCHUNK * CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NCHUNK - 1);
   localparam logic [PADW-1:0] CHUNK_MASK = PADW'({CHUNK{1'b1}});

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COMPUTE = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [1:0]       state, state_next;
   logic [IDXW-1:0]  idx;
   logic             carry;
   logic [WIDTH-1:0] opa, opb;
   logic [PADW-1:0]  sum_pad;

   logic [31:0]      base;
   logic [CHUNK-1:0] chunk_a, chunk_b;
   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] final_sum, result;
   logic             final_c, ovf;

   logic             ack_next, carry_out_next;
   logic [WIDTH-1:0] dataout_next;
   logic [1:0]       exc_next;

   // Operands are zero-padded to a whole number of chunks, so for a partial
   // last chunk the carry into bit WIDTH lands in sum_pad[WIDTH].
   assign base      = 32'(idx) * 32'(CHUNK);
   assign chunk_a   = CHUNK'(PADW'(opa) >> base);
   assign chunk_b   = CHUNK'(PADW'(opb) >> base);
   assign chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
   assign final_sum = sum_pad[WIDTH-1:0];

   generate
      if (PADW == WIDTH) begin : g_full_chunk
         assign final_c = carry;
      end else begin : g_partial_chunk
         assign final_c = sum_pad[WIDTH];
      end
   endgenerate

   assign ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (final_sum[WIDTH-1] != opa[WIDTH-1]);

`ifdef ADDER_SAT_EN
   assign result = !ovf         ? final_sum :
                   opa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                  {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign result = final_sum;
`endif

   always_ff @(posedge CLK) begin
      if (RSTK) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (Adder_valid) state_next = S_COMPUTE;
         S_COMPUTE: begin
            if (!Adder_valid)         state_next = S_IDLE;
            else if (idx == LAST_IDX) state_next = S_DONE;
         end
         S_DONE:    state_next = S_RELEASE;
         S_RELEASE: if (!Adder_valid) state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   always_comb begin
      ack_next       = 1'b0;
      dataout_next   = Adder_dataout;
      carry_out_next = Adder_carryout;
      exc_next       = Adder_Exc;
      if (state == S_DONE) begin
         ack_next       = 1'b1;
         dataout_next   = result;
         carry_out_next = final_c;
         exc_next       = {1'b0, ovf};
      end
   end

   always_ff @(posedge CLK) begin
      if (RSTK) begin
         Adder_ack      <= 1'b0;
         Adder_dataout  <= '0;
         Adder_carryout <= 1'b0;
         Adder_Exc      <= 2'b00;
      end else begin
         Adder_ack      <= ack_next;
         Adder_dataout  <= dataout_next;
         Adder_carryout <= carry_out_next;
         Adder_Exc      <= exc_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (RSTK) begin
         idx     <= '0;
         carry   <= 1'b0;
         opa     <= '0;
         opb     <= '0;
         sum_pad <= '0;
      end else if (state == S_IDLE && Adder_valid) begin
         opa   <= Adder_datain1;
         opb   <= Adder_datain2;
         carry <= 1'b0;
         idx   <= '0;
      end else if (state == S_COMPUTE && Adder_valid) begin
         sum_pad <= (sum_pad & ~(CHUNK_MASK << base)) | (PADW'(chunk_sum[CHUNK-1:0]) << base);
         carry   <= chunk_sum[CHUNK];
         idx     <= idx + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_booth_adder_server.sv
`default_nettype none
// tb_booth_adder_server: directed vectors with hand-computed sums for booth_adder_server.
module tb_booth_adder_server;

   logic        CLK = 1'b0;
   logic        RSTK;
   logic        Adder_valid;
   logic [24:0] Adder_datain1, Adder_datain2;
   logic [24:0] Adder_dataout;
   logic        Adder_carryout;
   logic [1:0]  Adder_Exc;
   logic        Adder_ack;

   int checks = 0;
   int passed = 0;

   booth_adder_server dut (
      .CLK            (CLK),
      .RSTK           (RSTK),
      .Adder_valid    (Adder_valid),
      .Adder_datain1  (Adder_datain1),
      .Adder_datain2  (Adder_datain2),
      .Adder_dataout  (Adder_dataout),
      .Adder_carryout (Adder_carryout),
      .Adder_Exc      (Adder_Exc),
      .Adder_ack      (Adder_ack)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Raise valid, wait for ack, keep valid high `hold` more cycles, then drop it for one edge.
   // Edges counted from raising valid: the sampling edge plus 6 more, so ack shows after 7.
   task automatic do_req(input string tag, input logic [24:0] a, input logic [24:0] b,
                         input logic [24:0] d, input logic c, input logic [1:0] e, input int hold);
      int n;
      int extra;
      Adder_datain1 = a;
      Adder_datain2 = b;
      Adder_valid   = 1'b1;
      n = 0;
      while (!Adder_ack && n < 20) begin
         tick();
         n++;
      end
      check({tag, " latency"}, n, 7);
      check({tag, " dataout"}, Adder_dataout, d);
      check({tag, " carryout"}, Adder_carryout, c);
      check({tag, " exc"}, Adder_Exc, e);
      extra = 0;
      repeat (hold + 1) begin
         tick();
         if (Adder_ack) extra++;
      end
      check({tag, " single ack"}, extra, 0);
      Adder_valid = 1'b0;
      tick();
      check({tag, " dataout held"}, Adder_dataout, d);
   endtask

   initial begin
      int acks;
      RSTK          = 1'b1;
      Adder_valid   = 1'b0;
      Adder_datain1 = '0;
      Adder_datain2 = '0;
      tick();
      tick();
      check("reset dataout", Adder_dataout, 0);
      check("reset carryout", Adder_carryout, 0);
      check("reset exc", Adder_Exc, 0);
      check("reset ack", Adder_ack, 0);
      RSTK = 1'b0;
      tick();

      do_req("add 3+5", 25'h0000003, 25'h0000005, 25'h0000008, 1'b0, 2'b00, 0);
      do_req("add -1+1", 25'h1FFFFFF, 25'h0000001, 25'h0000000, 1'b1, 2'b00, 0);
`ifdef ADDER_SAT_EN
      do_req("pos ovf", 25'h0FFFFFF, 25'h0000001, 25'h0FFFFFF, 1'b0, 2'b01, 0);
      do_req("neg ovf", 25'h1000000, 25'h1000000, 25'h1000000, 1'b1, 2'b01, 0);
`else
      do_req("pos ovf", 25'h0FFFFFF, 25'h0000001, 25'h1000000, 1'b0, 2'b01, 0);
      do_req("neg ovf", 25'h1000000, 25'h1000000, 25'h0000000, 1'b1, 2'b01, 0);
`endif
      do_req("hold3 first", 25'h0000005, 25'h0000006, 25'h000000B, 1'b0, 2'b00, 3);
      do_req("hold3 next", 25'h0000010, 25'h1FFFFF0, 25'h0000000, 1'b1, 2'b00, 0);
      do_req("mid carries", 25'h0ABCDEF, 25'h0123456, 25'h0BE0245, 1'b0, 2'b00, 0);

      // Abort: valid drops before the second COMPUTE edge.
      Adder_datain1 = 25'h0000007;
      Adder_datain2 = 25'h0000009;
      Adder_valid   = 1'b1;
      tick();
      tick();
      Adder_valid = 1'b0;
      acks = 0;
      repeat (10) begin
         tick();
         if (Adder_ack) acks++;
      end
      check("abort no ack", acks, 0);
      check("abort dataout kept", Adder_dataout, 25'h0BE0245);
      do_req("after abort 2+2", 25'h0000002, 25'h0000002, 25'h0000004, 1'b0, 2'b00, 0);

      // Reset asserted during the third COMPUTE cycle.
      Adder_datain1 = 25'h0000003;
      Adder_datain2 = 25'h0000003;
      Adder_valid   = 1'b1;
      tick();
      tick();
      tick();
      RSTK = 1'b1;
      tick();
      check("midreset dataout", Adder_dataout, 0);
      check("midreset carryout", Adder_carryout, 0);
      check("midreset exc", Adder_Exc, 0);
      check("midreset ack", Adder_ack, 0);
      RSTK        = 1'b0;
      Adder_valid = 1'b0;
      acks = 0;
      repeat (8) begin
         tick();
         if (Adder_ack) acks++;
      end
      check("midreset no ack", acks, 0);
      do_req("after reset ripple", 25'h1555555, 25'h0AAAAAB, 25'h0000000, 1'b1, 2'b00, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
